// File: rtl/uart_cmd_parser.sv
// Command frame parser behind the UART receiver: sync, address, 4 data bytes, XOR checksum.
// Each valid frame issues one 32-bit register write; bad or stalled frames raise frame_err.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd3200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_16x_tick,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cfg_wr_en,
  output logic [7:0]  cfg_addr,
  output logic [31:0] cfg_wdata,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_t;

  localparam int unsigned CNT_W = 16;

  state_t            state, state_nxt;
  logic [7:0]        addr_sh;
  logic [31:0]       data_sh;
  logic [7:0]        acc;
  logic [1:0]        byte_cnt;
  logic [CNT_W-1:0]  to_cnt;
  logic              timeout_c;
  logic              wr_c;
  logic              csum_err_c;

  // A byte arriving in the same cycle always beats an expiring tick.
  assign timeout_c = (state != IDLE) && baud_16x_tick && !rx_valid &&
                     (to_cnt == TIMEOUT_TICKS - CNT_W'(1));

  // Next-state and frame-verdict decode
  always_comb begin
    state_nxt  = state;
    wr_c       = 1'b0;
    csum_err_c = 1'b0;
    if (timeout_c) begin
      state_nxt = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE: if (rx_data == SYNC_BYTE) state_nxt = ADDR;
        ADDR: state_nxt = DATA;
        DATA: if (byte_cnt == 2'd3) state_nxt = CSUM;
        CSUM: begin
          state_nxt = IDLE;
          if (rx_data == acc) wr_c = 1'b1;
          else                csum_err_c = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_wr_en <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      cfg_addr  <= 8'd0;
      cfg_wdata <= 32'd0;
      err_code  <= 2'b00;
      addr_sh   <= 8'd0;
      data_sh   <= 32'd0;
      acc       <= 8'd0;
      byte_cnt  <= 2'd0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      cfg_wr_en <= wr_c;
      frame_err <= timeout_c | csum_err_c;

      if (wr_c) begin
        cfg_addr  <= addr_sh;
        cfg_wdata <= data_sh;
      end

      if (csum_err_c)     err_code <= 2'b01;
      else if (timeout_c) err_code <= 2'b10;

      // Frame assembly; the sync byte is not part of the checksum
      if (rx_valid) begin
        case (state)
          IDLE: if (rx_data == SYNC_BYTE) acc <= 8'd0;
          ADDR: begin
            addr_sh  <= rx_data;
            acc      <= rx_data;
            byte_cnt <= 2'd0;
          end
          DATA: begin
            data_sh  <= {data_sh[23:0], rx_data};
            acc      <= acc ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
          default: ;
        endcase
      end

      // Inter-byte stall counter, saturating, held at zero outside a frame
      if (state == IDLE || rx_valid || timeout_c) begin
        to_cnt <= '0;
      end else if (baud_16x_tick && (to_cnt != {CNT_W{1'b1}})) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
    end
  end

endmodule
